// File: rtl/quick_spi_arbiter_if.sv
// rtl/quick_spi_arbiter_if.sv - command/completion bus between the arbiter and the quick_spi master
interface quick_spi_arbiter_if #(
    parameter int SLAVE_W = 2,
    parameter int OUT_W   = 16,
    parameter int IN_W    = 8
);
    logic               spi_start_transaction;
    logic [SLAVE_W-1:0] spi_slave;
    logic               spi_operation;
    logic [OUT_W-1:0]   spi_outgoing_data;
    logic               spi_end_of_transaction;
    logic [IN_W-1:0]    spi_incoming_data;

    modport master (
        output spi_start_transaction,
        output spi_slave,
        output spi_operation,
        output spi_outgoing_data,
        input  spi_end_of_transaction,
        input  spi_incoming_data
    );

    modport slave (
        input  spi_start_transaction,
        input  spi_slave,
        input  spi_operation,
        input  spi_outgoing_data,
        output spi_end_of_transaction,
        output spi_incoming_data
    );
endinterface

// File: rtl/quick_spi_arbiter.sv
// rtl/quick_spi_arbiter.sv - round-robin sequencer sharing one quick_spi master, with completion watchdog
module quick_spi_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int SLAVE_W = 2,
    parameter int OUT_W   = 16,
    parameter int IN_W    = 8,
    parameter int TIMEOUT = 1024,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*SLAVE_W-1:0] req_slave,
    input  logic [NUM_REQ-1:0]         req_operation,
    input  logic [NUM_REQ*OUT_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_accept,
    output logic                       rsp_valid,
    output logic [ID_W-1:0]            rsp_id,
    output logic [IN_W-1:0]            rsp_data,
    output logic                       rsp_error,
    output logic                       busy,
    quick_spi_arbiter_if.master        spi
);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t             state_q;
    state_t             state_d;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    gnt_id_q;
    logic [15:0]        wd_q;
    logic [SLAVE_W-1:0] slave_q;
    logic               op_q;
    logic [OUT_W-1:0]   data_q;
    logic [IN_W-1:0]    rdata_q;
    logic               rerr_q;
    logic               start_pulse;

    logic               sel_found;
    logic [ID_W-1:0]    sel_id;
    int                 sel_idx;
    logic               wd_expire;

    assign wd_expire = (wd_q == 16'(TIMEOUT - 1));

    // First requesting index at or above rr_ptr, wrapping past NUM_REQ-1.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        sel_idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_idx = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!sel_found && req_valid[sel_idx]) begin
                sel_found = 1'b1;
                sel_id    = ID_W'(sel_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sel_found) state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (spi.spi_end_of_transaction || wd_expire) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are decoded from the registered state, so they land one cycle after the decision.
    always_comb begin
        req_accept  = '0;
        start_pulse = 1'b0;
        rsp_valid   = 1'b0;
        rsp_id      = '0;
        rsp_data    = '0;
        rsp_error   = 1'b0;
        busy        = (state_q != IDLE);
        case (state_q)
            START: begin
                req_accept[gnt_id_q] = 1'b1;
                start_pulse          = 1'b1;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_id    = gnt_id_q;
                rsp_data  = rdata_q;
                rsp_error = rerr_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
            gnt_id_q <= '0;
            wd_q     <= '0;
            slave_q  <= '0;
            op_q     <= 1'b0;
            data_q   <= '0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_found) begin
                        gnt_id_q <= sel_id;
                        slave_q  <= req_slave[int'(sel_id)*SLAVE_W +: SLAVE_W];
                        op_q     <= req_operation[sel_id];
                        data_q   <= req_data[int'(sel_id)*OUT_W +: OUT_W];
                    end
                end
                START: wd_q <= '0;
                WAIT: begin
                    wd_q <= wd_q + 16'd1;
                    // Completion takes priority over a watchdog expiry in the same cycle.
                    if (spi.spi_end_of_transaction) begin
                        rdata_q <= spi.spi_incoming_data;
                        rerr_q  <= 1'b0;
                    end else if (wd_expire) begin
                        rdata_q <= '0;
                        rerr_q  <= 1'b1;
                    end
                end
                RESP: rr_ptr_q <= (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign spi.spi_start_transaction = start_pulse;
    assign spi.spi_slave             = slave_q;
    assign spi.spi_operation         = op_q;
    assign spi.spi_outgoing_data     = data_q;

endmodule
